// File: rtl/seq_alu_if.sv
// seq_alu_if: start/op/operand request and result/status bundle for seq_alu
interface seq_alu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic             dz;
  modport master(output start, op, a, b, input result, zero, busy, done, dz);
  modport slave(input start, op, a, b, output result, zero, busy, done, dz);
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU, single-cycle logic/arith plus iterative shift-add mul and restoring div
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic  clk,
  input logic  rst,
  seq_alu_if.slave bus
);
  localparam logic [2:0] op_add = 3'b000;
  localparam logic [2:0] op_sub = 3'b001;
  localparam logic [2:0] op_and = 3'b010;
  localparam logic [2:0] op_or  = 3'b011;
  localparam logic [2:0] op_slt = 3'b100;
  localparam logic [2:0] op_mul = 3'b101;
  localparam logic [2:0] op_div = 3'b110;
  typedef enum logic [1:0] {s_idle, s_mul, s_div} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] ra, rb, acc;
  logic [WIDTH-1:0] sc, madd, rem_n, q_n, fin;
  logic [WIDTH:0]   trial;
  logic             go_mul, go_div;
  assign go_mul  = bus.start && bus.op == op_mul;
  assign go_div  = bus.start && bus.op == op_div && bus.b != '0;
  assign bus.busy = state != s_idle;
  // single-cycle result; div here only ever means divide-by-zero, nop holds the old result
  always_comb begin
    sc = bus.op == op_add ? bus.a + bus.b :
         bus.op == op_sub ? bus.a - bus.b :
         bus.op == op_and ? bus.a & bus.b :
         bus.op == op_or  ? bus.a | bus.b :
         bus.op == op_slt ? {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)} :
         bus.op == op_div ? '1 : bus.result;
  end
  // one iteration step: ra is multiplicand / dividend-quotient shifter, rb multiplier / divisor, acc product / remainder
  always_comb begin
    madd  = acc + (rb[0] ? ra : '0);
    trial = {acc, ra[WIDTH-1]} - {1'b0, rb};
    rem_n = trial[WIDTH] ? {acc[WIDTH-2:0], ra[WIDTH-1]} : trial[WIDTH-1:0];
    q_n   = {ra[WIDTH-2:0], ~trial[WIDTH]};
    fin   = state == s_mul ? madd : q_n;
  end
  // next state: enter iteration from idle, leave after the count-0 step
  always_comb begin
    state_n = state;
    if (state == s_idle)
      state_n = go_mul ? s_mul : go_div ? s_div : s_idle;
    else if (cnt == '0)
      state_n = s_idle;
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= s_idle;
    else state <= state_n;
  // datapath, counter and registered outputs
  always_ff @(posedge clk)
    if (rst) begin
      cnt        <= '0;
      ra         <= '0;
      rb         <= '0;
      acc        <= '0;
      bus.result <= '0;
      bus.zero   <= 1'b1;
      bus.done   <= 1'b0;
      bus.dz     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == s_idle && bus.start) begin
        ra  <= bus.a;
        rb  <= bus.b;
        acc <= '0;
        cnt <= CNT_W'(WIDTH - 1);
        if (!go_mul && !go_div) begin
          bus.result <= sc;
          bus.zero   <= sc == '0;
          bus.dz     <= bus.op == op_div;
          bus.done   <= 1'b1;
        end
      end else if (state != s_idle) begin
        acc <= state == s_mul ? madd : rem_n;
        ra  <= state == s_mul ? ra << 1 : q_n;
        rb  <= state == s_mul ? rb >> 1 : rb;
        cnt <= cnt == '0 ? '0 : cnt - CNT_W'(1);
        if (cnt == '0) begin
          bus.result <= fin;
          bus.zero   <= fin == '0;
          bus.dz     <= 1'b0;
          bus.done   <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: table, hand-sequence and random checks of seq_alu against an arithmetic model
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] prev = '0;
  always #5 clk = ~clk;
  seq_alu_if #(.WIDTH(32)) bus ();
  seq_alu #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic        zero, dz;
    int          lat;
    string       name;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    logic [63:0] prod;
    prod = {32'b0, a} * {32'b0, b};
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: return prod[31:0];
      3'd6: return b == 0 ? 32'hFFFF_FFFF : a / b;
      default: return p;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic zero, output logic dz, output int lat);
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = bus.result; zero = bus.zero; dz = bus.dz;
  endtask

  task automatic apply(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez, input logic edz, input int elat);
    logic [31:0] r;
    logic z, d;
    int lat;
    do_op(op, a, b, r, z, d, lat);
    check({name, ".result"}, r, er);
    check({name, ".zero"}, {31'b0, z}, {31'b0, ez});
    check({name, ".dz"}, {31'b0, d}, {31'b0, edz});
    check({name, ".latency"}, lat, elat);
    prev = er;
  endtask

  initial begin
    logic [31:0] ra, rb, er, got;
    logic [2:0]  rop;
    int ndone, dlat;
    bus.start = 1'b0; bus.op = 3'd7; bus.a = '0; bus.b = '0;
    tbl[0] = '{3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1, "add_wrap"};
    tbl[1] = '{3'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, "sub_neg"};
    tbl[2] = '{3'd4, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1, "slt_signed"};
    tbl[3] = '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1, "and"};
    tbl[4] = '{3'd3, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1'b0, 1, "or"};
    tbl[5] = '{3'd5, 32'h0001_2345, 32'h0001_0000, 32'h2345_0000, 1'b0, 1'b0, 33, "mul"};
    tbl[6] = '{3'd6, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33, "div"};
    tbl[7] = '{3'd6, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1, "div_by_zero"};
    tbl[8] = '{3'd0, 32'd4, 32'd5, 32'd9, 1'b0, 1'b0, 1, "add_9"};
    tbl[9] = '{3'd7, 32'd123, 32'd456, 32'd9, 1'b0, 1'b0, 1, "nop_hold"};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset.result", bus.result, 32'd0);
    check("reset.zero", {31'b0, bus.zero}, 32'd1);
    check("reset.busy", {31'b0, bus.busy}, 32'd0);
    check("reset.done", {31'b0, bus.done}, 32'd0);
    check("reset.dz", {31'b0, bus.dz}, 32'd0);
    for (int i = 0; i < 10; i++)
      apply(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].zero, tbl[i].dz, tbl[i].lat);

    // mul with operand changes and a stray START while busy
    @(negedge clk);
    bus.op = 3'd5; bus.a = 32'h0001_2345; bus.b = 32'h0001_0000; bus.start = 1'b1;
    ndone = 0; dlat = 0; got = '0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 3) check("mul_mid.busy", {31'b0, bus.busy}, 32'd1);
      if (i == 5) begin bus.a = $urandom; bus.b = $urandom; bus.op = 3'd0; bus.start = 1'b1; end
      if (i == 6) bus.start = 1'b0;
      if (bus.done) begin ndone++; dlat = i; got = bus.result; end
    end
    check("mul_mid.done_count", ndone, 32'd1);
    check("mul_mid.latency", dlat, 32'd33);
    check("mul_mid.result", got, 32'h2345_0000);

    // add issued in the DONE cycle of a mul
    @(negedge clk);
    bus.op = 3'd5; bus.a = 32'd6; bus.b = 32'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dlat = 1;
    while (!bus.done && dlat < 100) begin @(negedge clk); dlat++; end
    check("b2b.mul_latency", dlat, 32'd33);
    check("b2b.mul_result", bus.result, 32'd42);
    bus.op = 3'd0; bus.a = 32'd100; bus.b = 32'd23; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b.add_done", {31'b0, bus.done}, 32'd1);
    check("b2b.add_result", bus.result, 32'd123);
    @(negedge clk);
    check("b2b.done_drop", {31'b0, bus.done}, 32'd0);
    prev = 32'd123;

    // reset in the middle of a mul
    @(negedge clk);
    bus.op = 3'd5; bus.a = 32'd3; bus.b = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid.result", bus.result, 32'd0);
    check("rst_mid.zero", {31'b0, bus.zero}, 32'd1);
    check("rst_mid.busy", {31'b0, bus.busy}, 32'd0);
    check("rst_mid.done", {31'b0, bus.done}, 32'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin @(negedge clk); if (bus.done) ndone++; end
    check("rst_mid.no_done", ndone, 32'd0);
    prev = '0;

    // randomized ops against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 300));
      er = model(rop, ra, rb, prev);
      apply($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, er, er == 0,
            rop == 3'd6 && rb == 0, (rop == 3'd5 || (rop == 3'd6 && rb != 0)) ? 33 : 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
